mux_n1_rr: RTL and testbench

Parametrised N:1, W-bit multiplexer with a registered output and a valid/ready handshake. It is the next step up from the single-bit 2:1 select mux used in the 4-bit ALU datapath. The block runs in one of two modes. In fixed-select mode it forwards the channel chosen by `s`. In round-robin mode it arbitrates fairly among requesting channels. It sits between the ALU operand/result sources and any consumer that can stall.

---
 rtl/mux_n1_rr.sv | 121 ++++++++++++
 tb/tb_mux_n1_rr.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_n1_rr.sv
// mux_n1_rr: parametrised N:1, W-bit multiplexer with a registered output
// stage and valid/ready handshakes on both sides.
//   mode = 0 : fixed select, the channel addressed by s is forwarded.
//   mode = 1 : round-robin arbitration among requesting channels.
//
// Ports
//   clk       in   1     rising-edge clock
//   rst       in   1     synchronous, active-high reset
//   mode      in   1     0 = fixed select, 1 = round-robin
//   s         in   SW    channel select (fixed mode only)
//   in_data   in   N*W   flat channel data, channel i at [i*W +: W]
//   in_valid  in   N     per-channel request
//   in_ready  out  N     per-channel accept, at most one bit high
//   y         out  W     registered output data
//   y_valid   out  1     y holds an unconsumed word
//   y_ready   in   1     consumer accepts y
//   y_ch      out  SW    index of the channel that produced y
module mux_n1_rr #(
    parameter  int W  = 4,
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [SW-1:0]   s,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    y,
    output logic            y_valid,
    input  logic            y_ready,
    output logic [SW-1:0]   y_ch
);

    logic [W-1:0]  r_y;
    logic [SW-1:0] r_y_ch;
    logic          r_y_valid;
    logic [SW-1:0] r_ptr;

    logic          w_load_ok;
    logic          w_gnt_vld;
    logic [SW-1:0] w_gnt;
    logic [W-1:0]  w_gnt_data;
    logic          w_xfer;

    assign w_load_ok = !r_y_valid || y_ready;

    // Grant selection. In round-robin mode the scan starts at r_ptr and the
    // index wraps explicitly at N, so non-power-of-2 N never visits an
    // unused index. In fixed mode s values >= N match no channel.
    always_comb begin
        int unsigned   idx;
        logic [SW-1:0] w_idx;
        w_gnt_vld  = 1'b0;
        w_gnt      = '0;
        w_gnt_data = '0;
        idx        = 0;
        w_idx      = '0;
        if (!mode) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (s == SW'(i) && in_valid[i]) begin
                    w_gnt_vld  = 1'b1;
                    w_gnt      = SW'(i);
                    w_gnt_data = in_data[i*W +: W];
                end
            end
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                idx = 32'(r_ptr) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                w_idx = SW'(idx);
                if (!w_gnt_vld && in_valid[w_idx]) begin
                    w_gnt_vld  = 1'b1;
                    w_gnt      = w_idx;
                    w_gnt_data = in_data[idx*W +: W];
                end
            end
        end
    end

    // A transfer needs a grant and room in the output stage; nothing is
    // accepted while reset is asserted.
    assign w_xfer = !rst && w_gnt_vld && w_load_ok;

    always_comb begin
        in_ready = '0;
        if (w_xfer) begin
            in_ready[w_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y       <= '0;
            r_y_ch    <= '0;
            r_y_valid <= 1'b0;
            r_ptr     <= '0;
        end else if (w_xfer) begin
            r_y       <= w_gnt_data;
            r_y_ch    <= w_gnt;
            r_y_valid <= 1'b1;
            if (mode) begin
                if (w_gnt == SW'(N-1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_gnt + 1'b1;
                end
            end
        end else if (r_y_valid && y_ready) begin
            r_y_valid <= 1'b0;
        end
    end

    assign y       = r_y;
    assign y_ch    = r_y_ch;
    assign y_valid = r_y_valid;

endmodule

// File: tb/tb_mux_n1_rr.sv
// tb_mux_n1_rr: scoreboard bench for mux_n1_rr. A driver applies stimulus
// once per cycle, predicts in_ready from a behavioural model of the grant
// rules and pushes every accepted word into a queue; a monitor pops and
// compares each word the DUT presents. A second instance with N=3 covers
// the out-of-range select and reset-while-full cases.
module tb_mux_n1_rr;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           mode = 1'b0;
    logic [SW-1:0]  s = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   y;
    logic           y_valid;
    logic           y_ready = 1'b1;
    logic [SW-1:0]  y_ch;

    logic        rst3 = 1'b1;
    logic        mode3 = 1'b0;
    logic [1:0]  s3 = '0;
    logic [11:0] in_data3 = '0;
    logic [2:0]  in_valid3 = '0;
    logic [2:0]  in_ready3;
    logic [3:0]  y3;
    logic        y_valid3;
    logic        y_ready3 = 1'b1;
    logic [1:0]  y_ch3;

    mux_n1_rr #(.W(W), .N(N)) dut (
        .clk(clk), .rst(rst), .mode(mode), .s(s), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .y(y), .y_valid(y_valid),
        .y_ready(y_ready), .y_ch(y_ch)
    );

    mux_n1_rr #(.W(4), .N(3)) dut3 (
        .clk(clk), .rst(rst3), .mode(mode3), .s(s3), .in_data(in_data3),
        .in_valid(in_valid3), .in_ready(in_ready3), .y(y3), .y_valid(y_valid3),
        .y_ready(y_ready3), .y_ch(y_ch3)
    );

    typedef struct {
        logic [W-1:0] d;
        int           ch;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   m_yv  = 1'b0;
    int   m_ptr = 0;

    localparam logic [N*W-1:0] DATA_DCBA = 16'hDCBA;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Grant as stated by the rules: fixed mode takes s if it names a valid
    // channel, round-robin takes the first valid channel from ptr onwards.
    function automatic int model_grant(input bit md, input int sel,
                                       input bit [N-1:0] v, input int p);
        if (!md) begin
            if (sel < N) begin
                if (v[sel]) return sel;
            end
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic cycle(input bit rs, input bit md, input int sel, input bit [N-1:0] v,
                         input bit [N*W-1:0] dat, input bit yr);
        int           g;
        logic [N-1:0] er;
        @(posedge clk);
        #2;
        rst      = rs;
        mode     = md;
        s        = SW'(sel);
        in_valid = v;
        in_data  = dat;
        y_ready  = yr;
        #1;
        check("y_valid", 32'(y_valid), 32'(m_yv));
        g  = model_grant(md, sel, v, m_ptr);
        er = '0;
        if (!rs && g >= 0 && (!m_yv || yr)) er[g] = 1'b1;
        check("in_ready", 32'(in_ready), 32'(er));
        if (rs) begin
            m_yv  = 1'b0;
            m_ptr = 0;
            q.delete();
        end else if (er != '0) begin
            q.push_back('{d: dat[g*W +: W], ch: g});
            m_yv = 1'b1;
            if (md) m_ptr = (g + 1) % N;
        end else if (m_yv && yr) begin
            m_yv = 1'b0;
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 0, '0, DATA_DCBA, 1'b1);
    endtask

    // Monitor: every presented word must match the oldest predicted word.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && y_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got y=%0h ch=%0d expected none", y, y_ch);
                end else begin
                    check("y", 32'(y), 32'(q[0].d));
                    check("y_ch", 32'(y_ch), 32'(q[0].ch));
                    if (y_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset with all channels requesting.
        cycle(1'b1, 1'b0, 0, 4'b1111, DATA_DCBA, 1'b1);
        cycle(1'b1, 1'b0, 0, 4'b1111, DATA_DCBA, 1'b1);
        idle();
        check("rst_y", 32'(y), 32'h0);
        check("rst_y_ch", 32'(y_ch), 32'h0);

        // Fixed-select sweep.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, i, 4'b1111, DATA_DCBA, 1'b1);

        // Round-robin: all requesting, then alternating pair.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 0, 4'b1111, DATA_DCBA, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 0, 4'b1010, DATA_DCBA, 1'b1);

        // Back-pressure: load C, stall three cycles, then drain and load A.
        cycle(1'b0, 1'b0, 2, 4'b0100, DATA_DCBA, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 2, 4'b0100, DATA_DCBA, 1'b0);
            check("hold_y", 32'(y), 32'hC);
        end
        cycle(1'b0, 1'b0, 0, 4'b0001, DATA_DCBA, 1'b1);
        idle();
        check("b2b_y", 32'(y), 32'hA);

        // N=3 instance: out-of-range select, then reset while full.
        idle();
        rst3 = 1'b0; mode3 = 1'b0; s3 = 2'd3; in_valid3 = 3'b111;
        in_data3 = 12'hCBA; y_ready3 = 1'b1;
        #1;
        check("n3_sel3_ready", 32'(in_ready3), 32'h0);
        idle();
        check("n3_sel3_valid", 32'(y_valid3), 32'h0);
        s3 = 2'd1;
        #1;
        check("n3_sel1_ready", 32'(in_ready3), 32'h2);
        idle();
        check("n3_load_valid", 32'(y_valid3), 32'h1);
        check("n3_load_y", 32'(y3), 32'hB);
        check("n3_load_ch", 32'(y_ch3), 32'h1);
        rst3 = 1'b1;
        #1;
        check("n3_rst_ready", 32'(in_ready3), 32'h0);
        idle();
        check("n3_rst_valid", 32'(y_valid3), 32'h0);

        // Randomised traffic with occasional resets and mode flips.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, N-1)), 4'($urandom), 16'($urandom),
                  ($urandom_range(0, 3) != 0));
        end

        // Drain: every predicted word must have been presented.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0, '0, DATA_DCBA, 1'b1);
        check("drain_empty", 32'(q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
